// File: rtl/regfile_pkg.sv
// Shared constants for the register-file arbiter: default widths, FSM encoding, requester ids.
// No logic; imported by the arbiter top and its round-robin sub-block.
// Requester id REQ_A indexes bit 0 of the request vector, REQ_B bit 1.
package regfile_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bundle of the two requester handshakes and the register-file pin group.
// master = arbiter side (drives gnt/err/rvalid/rdata and rf_* strobes).
// slave  = surrounding logic (requesters plus the register file itself).
interface regfile_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) ();

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_err;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_err;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              rf_wr;
  logic              rf_rd;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_in_data;
  logic [DATA_W-1:0] rf_out_data;

  modport master (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_err, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_err, b_rvalid, b_rdata,
    output rf_wr, rf_rd, rf_address, rf_in_data,
    input  rf_out_data
  );

  modport slave (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_err, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_err, b_rvalid, b_rdata,
    input  rf_wr, rf_rd, rf_address, rf_in_data,
    output rf_out_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on conflict the requester not granted last wins.
// Latency: combinational winner; pointer updates on the clock edge when advance=1.
// Backpressure: none; caller decides when a pick is consumed via advance.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner
);

  // Id of the most recent winner; reset to B so that A wins the first conflict.
  logic last_q;

  // Pick the winner from the current requests and the last-winner pointer.
  always_comb begin
    winner = REQ_A;
    if (req[REQ_A] && req[REQ_B]) begin
      winner = ~last_q;
    end else if (req[REQ_B]) begin
      winner = REQ_B;
    end
  end

  // Record every consumed pick, including uncontested ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= REQ_B;
    end else if (advance) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates requesters A/B onto a single-port register file; optional perf counters via REGFILE_ARB_PERF_EN.
// Latency: gnt 1 cycle after req, write lands in the gnt cycle, read rvalid 3 cycles after req.
// Backpressure: a requester holds req until gnt; the loser is re-evaluated once the FSM is back in IDLE.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_arbiter_if.master    bus,
  output logic                 busy,
  output logic [15:0]          cnt_a_gnt,
  output logic [15:0]          cnt_b_gnt,
  output logic [15:0]          cnt_conflict
);

  state_t            state_q;
  state_t            state_d;

  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_id;
  logic              cmd_oor;

  logic [1:0]        req;
  logic              winner;
  logic              advance;

  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  assign req     = {bus.b_req, bus.a_req};
  assign advance = (state_q == IDLE) && (|req);
  assign cmd_oor = (int'(cmd_addr) >= NUM_REGS);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .winner  (winner)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: reads take a RESP cycle, writes and rejected accesses return straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  state_d = (cmd_oor || cmd_we) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's command in IDLE; other requesters' inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_id    <= REQ_A;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (advance) begin
      cmd_id <= winner;
      if (winner == REQ_B) begin
        cmd_we    <= bus.b_we;
        cmd_addr  <= bus.b_addr;
        cmd_wdata <= bus.b_wdata;
      end else begin
        cmd_we    <= bus.a_we;
        cmd_addr  <= bus.a_addr;
        cmd_wdata <= bus.a_wdata;
      end
    end
  end

  // Decode grants and register-file strobes from the registered state only.
  always_comb begin
    bus.a_gnt      = 1'b0;
    bus.a_err      = 1'b0;
    bus.b_gnt      = 1'b0;
    bus.b_err      = 1'b0;
    bus.rf_wr      = 1'b0;
    bus.rf_rd      = 1'b0;
    bus.rf_address = '0;
    bus.rf_in_data = '0;
    busy           = (state_q != IDLE);
    if (state_q == ACCESS) begin
      if (cmd_id == REQ_B) begin
        bus.b_gnt = 1'b1;
        bus.b_err = cmd_oor;
      end else begin
        bus.a_gnt = 1'b1;
        bus.a_err = cmd_oor;
      end
      bus.rf_address = cmd_addr;
      if (!cmd_oor) begin
        if (cmd_we) begin
          bus.rf_wr      = 1'b1;
          bus.rf_in_data = cmd_wdata;
        end else begin
          bus.rf_rd = 1'b1;
        end
      end
    end
  end

  // Capture read data in RESP and pulse the owner's rvalid in the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      if (state_q == RESP) begin
        if (cmd_id == REQ_B) begin
          b_rvalid_q <= 1'b1;
          b_rdata_q  <= bus.rf_out_data;
        end else begin
          a_rvalid_q <= 1'b1;
          a_rdata_q  <= bus.rf_out_data;
        end
      end
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

`ifdef REGFILE_ARB_PERF_EN
  logic [15:0] cnt_a_q;
  logic [15:0] cnt_b_q;
  logic [15:0] cnt_c_q;

  // Saturating grant and conflict counters; a conflict is an IDLE cycle with both requests high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      if (bus.a_gnt && (cnt_a_q != 16'hFFFF)) cnt_a_q <= cnt_a_q + 16'd1;
      if (bus.b_gnt && (cnt_b_q != 16'hFFFF)) cnt_b_q <= cnt_b_q + 16'd1;
      if ((state_q == IDLE) && (&req) && (cnt_c_q != 16'hFFFF)) cnt_c_q <= cnt_c_q + 16'd1;
    end
  end

  assign cnt_a_gnt    = cnt_a_q;
  assign cnt_b_gnt    = cnt_b_q;
  assign cnt_conflict = cnt_c_q;
`else
  assign cnt_a_gnt    = '0;
  assign cnt_b_gnt    = '0;
  assign cnt_conflict = '0;
`endif

endmodule
